// File: rtl/ping_pang_pong_ctrl.sv
// Ownership controller for the ping/pang/pong packet buffers: hands buffers in
// ring order to snooper, CPU and forwarder, and counts accepted/rejected packets.
//
// Buffer state | meaning
// B_FREE       | empty, waiting for the snooper
// B_SN         | owned by the snooper (being written)
// B_PKT        | holds a packet, waiting for the CPU
// B_CPU        | owned by the CPU (being filtered)
// B_ACC        | accepted, waiting for the forwarder
// B_REJ        | rejected, forwarder will skip and free it
// B_FWD        | owned by the forwarder (being sent)
module ping_pang_pong_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sn_done,
  input  logic        cpu_done,
  input  logic        cpu_acc,
  input  logic        fwd_done,
  output logic [1:0]  sn_sel,
  output logic [1:0]  cpu_sel,
  output logic [1:0]  fwd_sel,
  output logic [31:0] acc_count,
  output logic [31:0] rej_count
);

  typedef enum logic [2:0] {
    B_FREE = 3'd0,
    B_SN   = 3'd1,
    B_PKT  = 3'd2,
    B_CPU  = 3'd3,
    B_ACC  = 3'd4,
    B_REJ  = 3'd5,
    B_FWD  = 3'd6
  } buf_state_t;

  buf_state_t  buf_q [3];
  buf_state_t  buf_d [3];
  logic [1:0]  sn_ptr_q, sn_ptr_d;
  logic [1:0]  cpu_ptr_q, cpu_ptr_d;
  logic [1:0]  fwd_ptr_q, fwd_ptr_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] rej_q, rej_d;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_q     <= '{default: B_FREE};
      sn_ptr_q  <= 2'd0;
      cpu_ptr_q <= 2'd0;
      fwd_ptr_q <= 2'd0;
      acc_q     <= 32'd0;
      rej_q     <= 32'd0;
    end else begin
      buf_q     <= buf_d;
      sn_ptr_q  <= sn_ptr_d;
      cpu_ptr_q <= cpu_ptr_d;
      fwd_ptr_q <= fwd_ptr_d;
      acc_q     <= acc_d;
      rej_q     <= rej_d;
    end
  end

  // Each buffer state belongs to exactly one agent, so the three agent
  // updates below never touch the same buffer in one edge. Claims test the
  // registered state, so a buffer freed this edge is claimed next edge.
  always_comb begin
    buf_d     = buf_q;
    sn_ptr_d  = sn_ptr_q;
    cpu_ptr_d = cpu_ptr_q;
    fwd_ptr_d = fwd_ptr_q;
    acc_d     = acc_q;
    rej_d     = rej_q;

    if (buf_q[sn_ptr_q] == B_SN) begin
      if (sn_done) begin
        buf_d[sn_ptr_q] = B_PKT;
        sn_ptr_d        = next_ptr(sn_ptr_q);
      end
    end else if (buf_q[sn_ptr_q] == B_FREE) begin
      buf_d[sn_ptr_q] = B_SN;
    end

    if (buf_q[cpu_ptr_q] == B_CPU) begin
      if (cpu_done) begin
        cpu_ptr_d = next_ptr(cpu_ptr_q);
        if (cpu_acc) begin
          buf_d[cpu_ptr_q] = B_ACC;
          acc_d            = acc_q + 32'd1;
        end else begin
          buf_d[cpu_ptr_q] = B_REJ;
          rej_d            = rej_q + 32'd1;
        end
      end
    end else if (buf_q[cpu_ptr_q] == B_PKT) begin
      buf_d[cpu_ptr_q] = B_CPU;
    end

    if (buf_q[fwd_ptr_q] == B_FWD) begin
      if (fwd_done) begin
        buf_d[fwd_ptr_q] = B_FREE;
        fwd_ptr_d        = next_ptr(fwd_ptr_q);
      end
    end else if (buf_q[fwd_ptr_q] == B_ACC) begin
      buf_d[fwd_ptr_q] = B_FWD;
    end else if (buf_q[fwd_ptr_q] == B_REJ) begin
      buf_d[fwd_ptr_q] = B_FREE;
      fwd_ptr_d        = next_ptr(fwd_ptr_q);
    end
  end

  always_comb begin
    sn_sel  = 2'b00;
    cpu_sel = 2'b00;
    fwd_sel = 2'b00;
    for (int i = 0; i < 3; i++) begin
      if (buf_q[i] == B_SN)  sn_sel  = 2'(i + 1);
      if (buf_q[i] == B_CPU) cpu_sel = 2'(i + 1);
      if (buf_q[i] == B_FWD) fwd_sel = 2'(i + 1);
    end
  end

  assign acc_count = acc_q;
  assign rej_count = rej_q;

endmodule

// File: tb/tb_ping_pang_pong_ctrl.sv
// Self-checking bench for ping_pang_pong_ctrl: directed scenarios plus a
// scoreboard of expected forwarder selects popped when the forwarder claims.
module tb_ping_pang_pong_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sn_done, cpu_done, cpu_acc, fwd_done;
  logic [1:0]  sn_sel, cpu_sel, fwd_sel;
  logic [31:0] acc_count, rej_count;

  int checks   = 0;
  int failures = 0;
  logic [1:0] fwd_exp_q[$];
  logic [1:0] fwd_prev = 2'b00;

  ping_pang_pong_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sn_done   (sn_done),
    .cpu_done  (cpu_done),
    .cpu_acc   (cpu_acc),
    .fwd_done  (fwd_done),
    .sn_sel    (sn_sel),
    .cpu_sel   (cpu_sel),
    .fwd_sel   (fwd_sel),
    .acc_count (acc_count),
    .rej_count (rej_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard pop on each new forwarder claim, plus the per-cycle
  // no-double-ownership check.
  always @(negedge clk) begin
    logic ov;
    if (rst_n === 1'b1) begin
      ov = (sn_sel != 2'b00 && (sn_sel == cpu_sel || sn_sel == fwd_sel)) ||
           (cpu_sel != 2'b00 && cpu_sel == fwd_sel);
      chk("no_overlap", 32'(ov), 32'd0);
      if (fwd_sel != 2'b00 && fwd_prev == 2'b00) begin
        if (fwd_exp_q.size() == 0) chk("fwd_unexpected", 32'(fwd_sel), 32'd0);
        else chk("fwd_claim", 32'(fwd_sel), 32'(fwd_exp_q.pop_front()));
      end
    end
    fwd_prev = fwd_sel;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s, input logic c, input logic a, input logic f);
    sn_done = s; cpu_done = c; cpu_acc = a; fwd_done = f;
    if (c && a) fwd_exp_q.push_back(cpu_sel);
    tick();
    sn_done = 1'b0; cpu_done = 1'b0; cpu_acc = 1'b0; fwd_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    fwd_exp_q.delete();
    rst_n = 1'b1;
    tick();
    chk("rst_sn01", 32'(sn_sel), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; sn_done = 1'b0; cpu_done = 1'b0; cpu_acc = 1'b0; fwd_done = 1'b0;
    tick(); tick();
    chk("reset_sn",  32'(sn_sel),  32'd0);
    chk("reset_cpu", 32'(cpu_sel), 32'd0);
    chk("reset_fwd", 32'(fwd_sel), 32'd0);
    chk("reset_acc", acc_count, 32'd0);
    chk("reset_rej", rej_count, 32'd0);

    // Reset release, idle
    rst_n = 1'b1;
    tick();
    chk("first_sn01", 32'(sn_sel), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_sn",  32'(sn_sel),  32'd1);
      chk("idle_cpu", 32'(cpu_sel), 32'd0);
      chk("idle_fwd", 32'(fwd_sel), 32'd0);
      chk("idle_cnt", acc_count | rej_count, 32'd0);
    end

    // Single accepted packet
    pulse(1, 0, 0, 0);
    chk("t2_sn_rel", 32'(sn_sel), 32'd0);
    chk("t2_cpu_wait", 32'(cpu_sel), 32'd0);
    tick();
    chk("t2_sn10", 32'(sn_sel), 32'd2);
    chk("t2_cpu01", 32'(cpu_sel), 32'd1);
    pulse(0, 1, 1, 0);
    chk("t2_cpu00", 32'(cpu_sel), 32'd0);
    chk("t2_acc1", acc_count, 32'd1);
    chk("t2_fwd_wait", 32'(fwd_sel), 32'd0);
    tick();
    chk("t2_fwd01", 32'(fwd_sel), 32'd1);
    pulse(0, 0, 0, 1);
    chk("t2_fwd00", 32'(fwd_sel), 32'd0);
    chk("t2_ping_free", 32'(dut.buf_q[0]), 32'd0);

    // Reject skip: packet 0 rejected, packet 1 accepted
    do_reset();
    pulse(1, 0, 0, 0);
    tick();
    chk("t3_cpu01", 32'(cpu_sel), 32'd1);
    pulse(1, 0, 0, 0);
    pulse(0, 1, 0, 0);
    chk("t3_rej1", rej_count, 32'd1);
    chk("t3_sn11", 32'(sn_sel), 32'd3);
    tick();
    chk("t3_skip_fwd00", 32'(fwd_sel), 32'd0);
    chk("t3_skip_ptr", 32'(dut.fwd_ptr_q), 32'd1);
    chk("t3_cpu10", 32'(cpu_sel), 32'd2);
    pulse(0, 1, 1, 0);
    chk("t3_fwd_wait", 32'(fwd_sel), 32'd0);
    tick();
    chk("t3_fwd10", 32'(fwd_sel), 32'd2);
    chk("t3_acc1", acc_count, 32'd1);
    chk("t3_rej1b", rej_count, 32'd1);
    pulse(0, 0, 0, 1);

    // Backpressure: CPU holds ping, snooper fills pang and pong then stalls
    do_reset();
    pulse(1, 0, 0, 0);
    tick();
    chk("t4_sn10", 32'(sn_sel), 32'd2);
    pulse(1, 0, 0, 0);
    tick();
    chk("t4_sn11", 32'(sn_sel), 32'd3);
    pulse(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_sn_stall", 32'(sn_sel), 32'd0);
    end
    pulse(0, 1, 1, 0);
    tick();
    chk("t4_fwd01", 32'(fwd_sel), 32'd1);
    chk("t4_cpu10", 32'(cpu_sel), 32'd2);
    pulse(0, 0, 0, 1);
    chk("t4_sn_still00", 32'(sn_sel), 32'd0);
    tick();
    chk("t4_sn_back01", 32'(sn_sel), 32'd1);

    // Simultaneous events with a stray fwd_done
    do_reset();
    pulse(1, 0, 0, 0);
    tick();
    pulse(1, 1, 0, 1);
    chk("t5_rej1", rej_count, 32'd1);
    chk("t5_acc0", acc_count, 32'd0);
    chk("t5_sn_ptr", 32'(dut.sn_ptr_q), 32'd2);
    chk("t5_cpu_ptr", 32'(dut.cpu_ptr_q), 32'd1);
    chk("t5_fwd_ptr", 32'(dut.fwd_ptr_q), 32'd0);
    chk("t5_ping_rej", 32'(dut.buf_q[0]), 32'd5);
    chk("t5_pang_pkt", 32'(dut.buf_q[1]), 32'd2);
    tick();
    chk("t5_fwd_ptr_skip", 32'(dut.fwd_ptr_q), 32'd1);
    chk("t5_sn11", 32'(sn_sel), 32'd3);
    chk("t5_cpu10", 32'(cpu_sel), 32'd2);

    // All agents busy, then reset mid-operation (with a coincident fwd_done)
    pulse(0, 1, 1, 0);
    pulse(1, 0, 0, 0);
    tick();
    chk("t6_sn01", 32'(sn_sel), 32'd1);
    chk("t6_cpu11", 32'(cpu_sel), 32'd3);
    chk("t6_fwd10", 32'(fwd_sel), 32'd2);
    rst_n = 1'b0; fwd_done = 1'b1;
    tick();
    fwd_done = 1'b0;
    chk("t6_rst_sn", 32'(sn_sel), 32'd0);
    chk("t6_rst_cpu", 32'(cpu_sel), 32'd0);
    chk("t6_rst_fwd", 32'(fwd_sel), 32'd0);
    chk("t6_rst_acc", acc_count, 32'd0);
    chk("t6_rst_rej", rej_count, 32'd0);
    fwd_exp_q.delete();
    rst_n = 1'b1;
    tick();
    chk("t6_restart_sn01", 32'(sn_sel), 32'd1);

    // Accept counter wrap
    @(negedge clk);
    force dut.acc_q = 32'hFFFF_FFFF;
    #1;
    release dut.acc_q;
    @(posedge clk); #1;
    chk("t7_preset", acc_count, 32'hFFFF_FFFF);
    pulse(1, 0, 0, 0);
    tick();
    pulse(0, 1, 1, 0);
    chk("t7_wrap", acc_count, 32'd0);
    tick();
    chk("t7_fwd01", 32'(fwd_sel), 32'd1);
    pulse(0, 0, 0, 1);

    tick(); tick();
    chk("sb_drained", 32'(fwd_exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
